// File: rtl/weighted_sum.sv
// weighted_sum: streaming N-input MAC of Q0.8 activations by Q8.8 weights plus bias, saturated to Q8.8
module weighted_sum #(
  parameter int N = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wgt_we,
  input  logic [$clog2(N+1)-1:0]   wgt_addr,
  input  logic [15:0]              wgt_data,
  input  logic                     arg_valid,
  output logic                     arg_ready,
  input  logic [7:0]               arg_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [15:0]              res_data
);
  localparam int AW = $clog2(N+1);
  localparam int ACC_W = 25 + $clog2(N) + 1;
  localparam int SW = ACC_W + 1;

  typedef enum logic {ACC, OUT} state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_nx;
  logic [15:0]             res_q, res_d;
  logic signed [15:0]      w_q [N+1];
  logic signed [24:0]      prod;
  logic signed [SW-1:0]    sum;
  logic [15:0]             sat;
  logic                    hs, last;

  assign hs        = arg_valid & (state_q == ACC);
  assign last      = cnt_q == AW'(N-1);
  assign prod      = $signed({1'b0, arg_data}) * w_q[cnt_q];
  assign acc_nx    = acc_q + {{(ACC_W-25){prod[24]}}, prod};
  assign sum       = {acc_nx[ACC_W-1], acc_nx} + {{(SW-24){w_q[N][15]}}, w_q[N], 8'h00};
  assign sat       = (&sum[SW-1:23] | ~|sum[SW-1:23]) ? sum[23:8] : (sum[SW-1] ? 16'h8000 : 16'h7fff);
  assign arg_ready = rst_n & (state_q == ACC);
  assign res_valid = state_q == OUT;
  assign res_data  = res_q;

  // weight file (0..N-1) and bias (N), writable in any state; out-of-range addresses dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= N; i++) w_q[i] <= '0;
    end else if (wgt_we && wgt_addr <= AW'(N)) begin
      w_q[wgt_addr] <= wgt_data;
    end
  end

  // state, counter, accumulator and latched result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  // accumulate on each handshake; the Nth one latches the saturated result and clears the accumulator
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    if (hs) begin
      state_d = last ? OUT : ACC;
      cnt_d   = last ? '0 : cnt_q + AW'(1);
      acc_d   = last ? '0 : acc_nx;
      res_d   = last ? sat : res_q;
    end
    if (state_q == OUT && res_ready) state_d = ACC;
  end
endmodule

// File: doc/weighted_sum.md
# weighted_sum

Streaming weighted-sum stage that feeds the sigmoid activation unit. It accepts N unsigned Q0.8 activations one per handshake and multiplies each by a stored signed Q8.8 weight. The products are accumulated at full precision, then a bias is added. The result is emitted as a saturated signed Q8.8 argument on a valid/ready output. It sits between the previous layer's activation outputs and the sigmoid `arg` input.

## Interface
- N, 4, number of inputs per result (≥1)
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- wgt_we  input  1  weight/bias write strobe
- wgt_addr  input  $clog2(N+1)  0..N-1 selects weight, N selects bias; other values ignored
- wgt_data  input  16  signed Q8.8 weight/bias value
- arg_valid  input  1  input activation valid
- arg_ready  output  1  block accepts activation
- arg_data  input  8  unsigned Q0.8 activation (0x80 = 0.5)
- res_valid  output  1  result valid
- res_ready  input  1  downstream accepts result
- res_data  output  16  signed Q8.8 weighted sum, saturated

## Operation
- Storage: N weight registers plus 1 bias register, all 16-bit signed. Reset value is 0.
- Write: if `wgt_we` is high on a clock edge, the register at `wgt_addr` takes `wgt_data`.
  - Writes are accepted in any state.
  - A product formed in the same cycle as a write uses the old weight.
- States: ACC and OUT. Reset enters ACC with cnt=0, acc=0.
- ACC:
  - `arg_ready`=1, `res_valid`=0.
  - On handshake (`arg_valid & arg_ready`): prod = signed({1'b0,arg_data}) × w[cnt]. This is a 9×16 multiply giving a 25-bit signed Q8.16 product.
  - acc += sign-extended prod, then cnt += 1.
  - Accumulator width: 25 + $clog2(N) + 1 bits. It never overflows internally.
  - On the handshake with cnt==N-1, the following happen on the same edge:
    - sum = acc_next + (bias <<< 8).
    - res_data ← sat16(sum >>> 8), an arithmetic shift that truncates toward −∞.
    - acc ← 0, cnt ← 0, state → OUT.
- OUT:
  - `res_valid`=1, `arg_ready`=0, `res_data` held stable.
  - On `res_valid & res_ready`, state → ACC.
- Saturation: values >0x7FFF clamp to 0x7FFF; values <−0x8000 clamp to 0x8000.
- Bias changes made while in OUT do not alter a result that is already latched.
- No partial flush: inputs are only ever consumed in groups of exactly N.

## Timing
- Reset values:
  - `arg_ready`=1 once `rst_n` is high (state ACC). It is 0 while `rst_n` is low.
  - `res_valid`=0, `res_data`=0x0000.
  - cnt=0, acc=0, all weights and bias 0.
- `arg_ready` and `res_valid` are decoded from the state register only. There is no combinational path from `arg_valid` or `res_ready`.
- Latency: `res_valid` rises the cycle after the Nth input handshake.
- Throughput: the minimum is N+1 cycles per result. That is N input cycles plus 1 OUT cycle, with `res_ready` held high.
- Backpressure: `res_valid` and `res_data` remain stable until accepted. No inputs are accepted meanwhile.
- Idle inputs: gaps in `arg_valid` stall accumulation without losing cnt or acc.
- Reset mid-operation (`rst_n` low in any state or cycle): immediately clears state, cnt, acc, weights, bias and the outputs.
- Output result: `res_data` is a pure function of the N input values in handshake order, the weights at each handshake edge, and the bias at the final edge.

## Test plan
- Reset/defaults: release reset, feed 4 inputs of 0xFF with res_ready=1.
  - Required: arg_ready=1 one cycle after release, and res_valid rises 1 cycle after the 4th handshake.
  - Required: res_data=0x0000, then arg_ready=1 on the next cycle.
- Nominal: weights all 0x0100, bias 0, inputs 0x80 ×4 -> res_data=0x0200. Then feed inputs 0x00,0x40,0x80,0xFF -> res_data=0x01BF.
- Saturation: weights all 0x7FFF, inputs 0xFF ×4 -> 0x7FFF. Weights all 0x8000, inputs 0xFF ×4 -> 0x8000.
- Bias and truncation: each case below is run with N=4.
  - Weights 0, bias 0xFF00 -> 0xFF00.
  - w0=0x0001, others 0, inputs 0x80,0,0,0, bias 0 -> 0x0000.
  - w0=0xFFFF, inputs 0x01,0,0,0 -> 0xFFFF.
- Backpressure/stall:
  - Drop arg_valid for 3 cycles between input 2 and input 3, with weights 0x0100 and inputs 0x80 ×4 -> result 0x0200.
  - Hold res_ready=0 for 5 cycles. Required: res_valid=1, res_data stable and arg_ready=0 throughout; accepted on the first cycle res_ready=1, and the next vector is accepted the cycle after.
- Reset mid-vector: after 2 handshakes assert rst_n low for 1 cycle.
  - Required: res_valid=0 and arg_ready=0 while low.
  - Feeding 4 inputs of 0x80 afterwards gives 0x0000, because the weights were cleared.
